// File: rtl/dram_cache_req_arbiter.sv
// rtl/dram_cache_req_arbiter.sv - read/write request arbiter with per-set ordering for the DRAM-cache tag lookup
module dram_cache_req_arbiter #(
    parameter int ID_W         = 16,
    parameter int ADDR_W       = 64,
    parameter int OFFSET_W     = 6,
    parameter int INDEX_W      = 4,
    parameter int MAX_RD_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ID_W-1:0]         arid_i,
    input  logic [ADDR_W-1:0]       araddr_i,
    input  logic                    arvalid_i,
    output logic                    arready_o,
    input  logic                    fifo_empty_i,
    input  logic [ID_W+ADDR_W:0]    fifo_data_i,
    input  logic                    fifo_afull_i,
    output logic                    fifo_rden_o,
    output logic                    req_valid_o,
    input  logic                    req_ready_i,
    output logic                    req_write_o,
    output logic [ID_W-1:0]         req_id_o,
    output logic [ADDR_W-1:0]       req_addr_o,
    output logic [INDEX_W-1:0]      req_index_o,
    input  logic                    done_valid_i,
    input  logic [INDEX_W-1:0]      done_index_i,
    output logic [(1<<INDEX_W)-1:0] busy_o
);

    localparam int NSETS = 1 << INDEX_W;
    localparam int CNT_W = $clog2(MAX_RD_BURST + 1);

    logic [INDEX_W-1:0] w_rd_idx;
    logic [INDEX_W-1:0] w_wr_idx;
    logic [INDEX_W-1:0] w_grant_idx;
    logic [ID_W-1:0]    w_wr_id;
    logic [ADDR_W-1:0]  w_wr_addr;
    logic               w_unused_fifo_bit;
    logic [NSETS-1:0]   w_done_mask;
    logic [NSETS-1:0]   w_eff_busy;
    logic [NSETS-1:0]   w_grant_mask;
    logic               w_rd_ok;
    logic               w_wr_ok;
    logic               w_stage_free;
    logic               w_burst_done;
    logic               w_grant_wr;
    logic               w_grant_rd;

    logic [NSETS-1:0]   r_busy;
    logic [CNT_W-1:0]   r_rd_cnt;
    logic               r_req_valid;
    logic               r_req_write;
    logic [ID_W-1:0]    r_req_id;
    logic [ADDR_W-1:0]  r_req_addr;
    logic [INDEX_W-1:0] r_req_index;

    // FIFO head layout: {spare bit, id, addr}; the spare bit carries nothing here
    assign w_wr_addr         = fifo_data_i[ADDR_W-1:0];
    assign w_wr_id           = fifo_data_i[ADDR_W +: ID_W];
    assign w_unused_fifo_bit = fifo_data_i[ID_W+ADDR_W];

    assign w_rd_idx = araddr_i[OFFSET_W +: INDEX_W];
    assign w_wr_idx = w_wr_addr[OFFSET_W +: INDEX_W];

    // Eligibility and grant: a same-cycle retire frees its set for this check
    always_comb begin
        w_done_mask  = '0;
        w_eff_busy   = '0;
        w_rd_ok      = 1'b0;
        w_wr_ok      = 1'b0;
        w_stage_free = 1'b0;
        w_burst_done = 1'b0;
        w_grant_wr   = 1'b0;
        w_grant_rd   = 1'b0;
        w_grant_idx  = '0;
        w_grant_mask = '0;

        if (done_valid_i) begin
            w_done_mask = NSETS'(1) << done_index_i;
        end
        w_eff_busy   = r_busy & ~w_done_mask;
        w_rd_ok      = arvalid_i & ~w_eff_busy[w_rd_idx];
        w_wr_ok      = ~fifo_empty_i & ~w_eff_busy[w_wr_idx];
        w_stage_free = ~r_req_valid | req_ready_i;
        w_burst_done = (r_rd_cnt == CNT_W'(MAX_RD_BURST));

        if (w_stage_free) begin
            if (w_wr_ok & (fifo_afull_i | w_burst_done | ~w_rd_ok)) begin
                w_grant_wr = 1'b1;
            end else if (w_rd_ok) begin
                w_grant_rd = 1'b1;
            end
        end

        w_grant_idx = w_grant_wr ? w_wr_idx : w_rd_idx;
        if (w_grant_wr | w_grant_rd) begin
            w_grant_mask = NSETS'(1) << w_grant_idx;
        end
    end

    // Handshakes are forced low while reset is held
    assign arready_o   = w_grant_rd & rst_n;
    assign fifo_rden_o = w_grant_wr & rst_n;

    // Output stage: load on grant, hold under backpressure, drop valid on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_valid <= 1'b0;
            r_req_write <= 1'b0;
            r_req_id    <= '0;
            r_req_addr  <= '0;
            r_req_index <= '0;
        end else if (w_grant_wr) begin
            r_req_valid <= 1'b1;
            r_req_write <= 1'b1;
            r_req_id    <= w_wr_id;
            r_req_addr  <= w_wr_addr;
            r_req_index <= w_wr_idx;
        end else if (w_grant_rd) begin
            r_req_valid <= 1'b1;
            r_req_write <= 1'b0;
            r_req_id    <= arid_i;
            r_req_addr  <= araddr_i;
            r_req_index <= w_rd_idx;
        end else if (req_ready_i) begin
            r_req_valid <= 1'b0;
        end
    end

    // Busy bitmap: retire clears, grant sets, and a grant wins over a retire to the same set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_done_mask) | w_grant_mask;
        end
    end

    // Read-burst counter: only counts reads that held off an eligible write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_cnt <= '0;
        end else if (w_grant_wr) begin
            r_rd_cnt <= '0;
        end else if (w_grant_rd & w_wr_ok & ~w_burst_done) begin
            r_rd_cnt <= r_rd_cnt + CNT_W'(1);
        end
    end

    assign req_valid_o = r_req_valid;
    assign req_write_o = r_req_write;
    assign req_id_o    = r_req_id;
    assign req_addr_o  = r_req_addr;
    assign req_index_o = r_req_index;
    assign busy_o      = r_busy;

endmodule

// File: tb/tb_dram_cache_req_arbiter.sv
// tb/tb_dram_cache_req_arbiter.sv - self-checking bench for dram_cache_req_arbiter
module tb_dram_cache_req_arbiter;

    localparam int ID_W    = 16;
    localparam int ADDR_W  = 64;
    localparam int INDEX_W = 4;
    localparam int NSETS   = 16;
    localparam int MAXB    = 4;

    logic              clk;
    logic              rst_n;
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic              fifo_empty;
    logic [ID_W+ADDR_W:0] fifo_data;
    logic              fifo_afull;
    logic              fifo_rden;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ID_W-1:0]   req_id;
    logic [ADDR_W-1:0] req_addr;
    logic [INDEX_W-1:0] req_index;
    logic              done_valid;
    logic [INDEX_W-1:0] done_index;
    logic [NSETS-1:0]  busy;

    int n_vec = 0;
    int n_bad = 0;

    // reference model state
    bit              m_valid;
    bit              m_write;
    logic [ID_W-1:0] m_id;
    logic [ADDR_W-1:0] m_addr;
    int              m_idx;
    bit              m_busy[NSETS];
    int              m_cnt;
    bit              m_gr;
    bit              m_gw;

    dram_cache_req_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arid_i       (arid),
        .araddr_i     (araddr),
        .arvalid_i    (arvalid),
        .arready_o    (arready),
        .fifo_empty_i (fifo_empty),
        .fifo_data_i  (fifo_data),
        .fifo_afull_i (fifo_afull),
        .fifo_rden_o  (fifo_rden),
        .req_valid_o  (req_valid),
        .req_ready_i  (req_ready),
        .req_write_o  (req_write),
        .req_id_o     (req_id),
        .req_addr_o   (req_addr),
        .req_index_o  (req_index),
        .done_valid_i (done_valid),
        .done_index_i (done_index),
        .busy_o       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          ar;
        logic [63:0] araddr;
        logic [15:0] arid;
        bit          fe;
        logic [63:0] faddr;
        logic [15:0] fid;
        bit          af;
        bit          rdy;
        bit          dn;
        logic [3:0]  didx;
        bit          e_ar;
        bit          e_rd;
        bit          e_valid;
        bit          e_write;
        logic [3:0]  e_idx;
        logic [15:0] e_busy;
    } vec_t;

    vec_t vt[13];

    function automatic vec_t mkv(bit ar, logic [63:0] a, logic [15:0] id, bit fe, logic [63:0] fa,
                                 logic [15:0] fid, bit af, bit rdy, bit dn, logic [3:0] di,
                                 bit ear, bit erd, bit ev, bit ew, logic [3:0] ei, logic [15:0] eb);
        vec_t v;
        v.ar = ar; v.araddr = a; v.arid = id; v.fe = fe; v.faddr = fa; v.fid = fid;
        v.af = af; v.rdy = rdy; v.dn = dn; v.didx = di;
        v.e_ar = ear; v.e_rd = erd; v.e_valid = ev; v.e_write = ew; v.e_idx = ei; v.e_busy = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(bit ar, logic [63:0] a, logic [15:0] id, bit fe, logic [63:0] fa,
                         logic [15:0] fid, bit af, bit rdy, bit dn, logic [3:0] di);
        arvalid    = ar;
        araddr     = a;
        arid       = id;
        fifo_empty = fe;
        fifo_data  = {1'($urandom_range(1)), fid, fa};
        fifo_afull = af;
        req_ready  = rdy;
        done_valid = dn;
        done_index = di;
    endtask

    task automatic m_reset();
        m_valid = 0; m_write = 0; m_id = '0; m_addr = '0; m_idx = 0; m_cnt = 0;
        for (int i = 0; i < NSETS; i++) m_busy[i] = 0;
    endtask

    // compare every output against the model for the current cycle, then advance model and clock
    task automatic step();
        bit eff[NSETS];
        bit rd_ok, wr_ok, free, gw, gr;
        int ridx, widx;
        logic [15:0] bpk;
        logic [63:0] faddr;
        #3;
        faddr = fifo_data[63:0];
        ridx  = int'((araddr / 64) % 16);
        widx  = int'((faddr / 64) % 16);
        for (int i = 0; i < NSETS; i++)
            eff[i] = m_busy[i] && !(done_valid && int'(done_index) == i);
        rd_ok = arvalid && !eff[ridx];
        wr_ok = !fifo_empty && !eff[widx];
        free  = !m_valid || req_ready;
        gw    = free && wr_ok && (fifo_afull || m_cnt == MAXB || !rd_ok);
        gr    = free && rd_ok && !gw;
        for (int i = 0; i < NSETS; i++) bpk[i] = m_busy[i];
        chk("m_arready", 64'(arready), 64'(gr));
        chk("m_rden", 64'(fifo_rden), 64'(gw));
        chk("m_valid", 64'(req_valid), 64'(m_valid));
        chk("m_busy", 64'(busy), 64'(bpk));
        if (m_valid) begin
            chk("m_write", 64'(req_write), 64'(m_write));
            chk("m_id", 64'(req_id), 64'(m_id));
            chk("m_addr", req_addr, m_addr);
            chk("m_idx", 64'(req_index), 64'(m_idx));
        end
        for (int i = 0; i < NSETS; i++)
            m_busy[i] = eff[i] || (gw && widx == i) || (gr && ridx == i);
        if (gw) begin
            m_valid = 1; m_write = 1; m_id = fifo_data[79:64]; m_addr = faddr; m_idx = widx; m_cnt = 0;
        end else if (gr) begin
            m_valid = 1; m_write = 0; m_id = arid; m_addr = araddr; m_idx = ridx;
            if (wr_ok && m_cnt < MAXB) m_cnt++;
        end else if (req_ready) begin
            m_valid = 0;
        end
        m_gr = gr;
        m_gw = gw;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(bit rdy);
        drive(0, 64'h0, 16'h0, 1, 64'h0, 16'h0, 0, rdy, 0, 4'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_reset();
    endtask

    initial begin
        logic [3:0] pat_rd;
        int         rd_n;
        int         wr_head;
        bit         gw_pat[10];
        bit         ar_v;
        logic [63:0] ar_a;
        logic [15:0] ar_i;
        bit         f_v;
        logic [63:0] f_a;
        logic [15:0] f_i;

        vt[0]  = mkv(1, 64'h1C0, 16'd3, 1, 64'h0,   16'd0, 0, 1, 0, 4'd0, 1, 0, 0, 0, 4'd0, 16'h0000);
        vt[1]  = mkv(0, 64'h0,   16'd0, 1, 64'h0,   16'd0, 0, 1, 0, 4'd0, 0, 0, 1, 0, 4'd7, 16'h0080);
        vt[2]  = mkv(0, 64'h0,   16'd0, 0, 64'h5C0, 16'd9, 0, 1, 0, 4'd0, 0, 0, 0, 0, 4'd0, 16'h0080);
        vt[3]  = mkv(0, 64'h0,   16'd0, 0, 64'h5C0, 16'd9, 0, 1, 1, 4'd7, 0, 1, 0, 0, 4'd0, 16'h0080);
        vt[4]  = mkv(0, 64'h0,   16'd0, 1, 64'h0,   16'd0, 0, 1, 0, 4'd0, 0, 0, 1, 1, 4'd7, 16'h0080);
        vt[5]  = mkv(0, 64'h0,   16'd0, 1, 64'h0,   16'd0, 0, 1, 1, 4'd7, 0, 0, 0, 0, 4'd0, 16'h0080);
        vt[6]  = mkv(0, 64'h0,   16'd0, 1, 64'h0,   16'd0, 0, 1, 0, 4'd0, 0, 0, 0, 0, 4'd0, 16'h0000);
        vt[7]  = mkv(1, 64'h040, 16'd5, 0, 64'h080, 16'd6, 1, 1, 0, 4'd0, 0, 1, 0, 0, 4'd0, 16'h0000);
        vt[8]  = mkv(1, 64'h040, 16'd5, 0, 64'h0C0, 16'd8, 0, 1, 0, 4'd0, 1, 0, 1, 1, 4'd2, 16'h0004);
        vt[9]  = mkv(0, 64'h0,   16'd0, 1, 64'h0,   16'd0, 0, 1, 0, 4'd0, 0, 0, 1, 0, 4'd1, 16'h0006);
        vt[10] = mkv(0, 64'h0,   16'd0, 1, 64'h0,   16'd0, 0, 1, 1, 4'd1, 0, 0, 0, 0, 4'd0, 16'h0006);
        vt[11] = mkv(0, 64'h0,   16'd0, 1, 64'h0,   16'd0, 0, 1, 1, 4'd2, 0, 0, 0, 0, 4'd0, 16'h0004);
        vt[12] = mkv(0, 64'h0,   16'd0, 1, 64'h0,   16'd0, 0, 1, 0, 4'd0, 0, 0, 0, 0, 4'd0, 16'h0000);

        // reset state, with requests offered while reset is held
        rst_n = 1'b0;
        drive(1, 64'h1C0, 16'd1, 0, 64'h0C0, 16'd2, 0, 1, 0, 4'd0);
        #12;
        chk("rst_arready", 64'(arready), 64'd0);
        chk("rst_rden", 64'(fifo_rden), 64'd0);
        chk("rst_valid", 64'(req_valid), 64'd0);
        chk("rst_write", 64'(req_write), 64'd0);
        chk("rst_id", 64'(req_id), 64'd0);
        chk("rst_addr", req_addr, 64'd0);
        chk("rst_idx", 64'(req_index), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_reset();

        // directed table: single read, set hazard with bypassed retire, urgency
        for (int k = 0; k < 13; k++) begin
            drive(vt[k].ar, vt[k].araddr, vt[k].arid, vt[k].fe, vt[k].faddr, vt[k].fid,
                  vt[k].af, vt[k].rdy, vt[k].dn, vt[k].didx);
            #2;
            chk($sformatf("t%0d_arready", k), 64'(arready), 64'(vt[k].e_ar));
            chk($sformatf("t%0d_rden", k), 64'(fifo_rden), 64'(vt[k].e_rd));
            chk($sformatf("t%0d_valid", k), 64'(req_valid), 64'(vt[k].e_valid));
            chk($sformatf("t%0d_busy", k), 64'(busy), 64'(vt[k].e_busy));
            if (vt[k].e_valid) begin
                chk($sformatf("t%0d_write", k), 64'(req_write), 64'(vt[k].e_write));
                chk($sformatf("t%0d_idx", k), 64'(req_index), 64'(vt[k].e_idx));
            end
            step();
        end

        // burst limit: four reads then one write, counter restarts
        do_reset();
        gw_pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        rd_n = 0;
        wr_head = 15;
        for (int k = 0; k < 10; k++) begin
            drive(1, 64'(rd_n) << 6, 16'(k), 0, 64'(wr_head) << 6, 16'(100 + k), 0, 1, 0, 4'd0);
            #2;
            chk($sformatf("burst%0d_arready", k), 64'(arready), 64'(!gw_pat[k]));
            chk($sformatf("burst%0d_rden", k), 64'(fifo_rden), 64'(gw_pat[k]));
            step();
            if (gw_pat[k]) wr_head--;
            else rd_n++;
        end

        // backpressure: outputs frozen, then drain and refill with no bubble
        do_reset();
        drive(1, 64'h040, 16'd1, 1, 64'h0, 16'd0, 0, 1, 0, 4'd0);
        step();
        for (int k = 0; k < 5; k++) begin
            drive(1, 64'h080, 16'd2, 0, 64'h0C0, 16'd3, 0, 0, 0, 4'd0);
            #2;
            chk("bp_valid", 64'(req_valid), 64'd1);
            chk("bp_idx", 64'(req_index), 64'd1);
            chk("bp_id", 64'(req_id), 64'd1);
            chk("bp_arready", 64'(arready), 64'd0);
            chk("bp_rden", 64'(fifo_rden), 64'd0);
            step();
        end
        drive(1, 64'h080, 16'd2, 0, 64'h0C0, 16'd3, 0, 1, 0, 4'd0);
        #2;
        chk("bp_release_arready", 64'(arready), 64'd1);
        step();
        drive(0, 64'h0, 16'd0, 0, 64'h0C0, 16'd3, 0, 1, 0, 4'd0);
        #2;
        chk("bp_nobubble_valid", 64'(req_valid), 64'd1);
        chk("bp_nobubble_idx", 64'(req_index), 64'd2);
        chk("bp_nobubble_rden", 64'(fifo_rden), 64'd1);
        step();

        // asynchronous reset mid-operation
        do_reset();
        drive(1, 64'h080, 16'd4, 1, 64'h0, 16'd0, 0, 1, 0, 4'd0);
        step();
        drive(1, 64'h1C0, 16'd5, 1, 64'h0, 16'd0, 0, 1, 0, 4'd0);
        step();
        drive(1, 64'h080, 16'd6, 1, 64'h0, 16'd0, 0, 0, 0, 4'd0);
        #2;
        chk("ar_pre_busy", 64'(busy), 64'h0084);
        chk("ar_pre_valid", 64'(req_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(req_valid), 64'd0);
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_arready", 64'(arready), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_reset();
        drive(1, 64'h080, 16'd7, 1, 64'h0, 16'd0, 0, 1, 0, 4'd0);
        #2;
        chk("ar_post_arready", 64'(arready), 64'd1);
        step();
        idle(1);
        #2;
        chk("ar_post_valid", 64'(req_valid), 64'd1);
        chk("ar_post_idx", 64'(req_index), 64'd2);
        step();

        // randomized traffic against the model; sources hold their head until granted
        do_reset();
        ar_v = 0; ar_a = '0; ar_i = '0;
        f_v = 0; f_a = '0; f_i = '0;
        for (int k = 0; k < 3000; k++) begin
            bit         dn;
            logic [3:0] di;
            int         start;
            if (!ar_v || m_gr) begin
                ar_v = ($urandom_range(3) != 0);
                ar_a = {$urandom, $urandom};
                ar_i = 16'($urandom);
            end
            if (!f_v || m_gw) begin
                f_v = ($urandom_range(2) != 0);
                f_a = {$urandom, $urandom};
                f_i = 16'($urandom);
            end
            dn = ($urandom_range(1) == 1);
            di = 4'($urandom_range(15));
            if (dn && $urandom_range(4) != 0) begin
                start = int'(di);
                for (int j = 0; j < NSETS; j++) begin
                    if (m_busy[(start + j) % NSETS]) begin
                        di = 4'((start + j) % NSETS);
                        break;
                    end
                end
            end
            drive(ar_v, ar_a, ar_i, !f_v, f_a, f_i, ($urandom_range(3) == 0),
                  ($urandom_range(3) != 0), dn, di);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
